fetch_bundle_queue: RTL

Parametrised multi-lane instruction fetch unit with a decoupling bundle queue. It sits between the instruction cache and decode. Each cycle it fetches an aligned bundle of LANES instructions, tracks block misses with a tag-matched refill handshake, and handles branch flushes and the stop instruction. Decode consumes bundles through a valid/ready handshake, which replaces the old stall/wait inputs.

---
 rtl/fetch_bundle_queue_if.sv | 34 +++
 rtl/fetch_bundle_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_bundle_queue_if.sv
// Fetch unit boundary: cache lookup, refill handshake, redirect and decode-side bundle stream.
// Bundle stream: a bundle transfers on a rising clk when out_valid && out_ready; while out_valid is high
// and out_ready is low the head fields are held stable, and out_valid never depends on out_ready.
interface fetch_bundle_queue_if #(
  parameter int ADDR_W = 32,
  parameter int LANES  = 2,
  parameter int TAG_W  = 10
);
  logic                  flush;
  logic [ADDR_W-1:0]     pc_branch;
  logic [ADDR_W-1:0]     fetch_pc;
  logic                  ic_hit;
  logic [LANES*32-1:0]   ic_data;
  logic                  miss_req;
  logic [TAG_W-1:0]      miss_tag;
  logic                  fill_valid;
  logic [TAG_W-1:0]      fill_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_instr;
  logic [ADDR_W-1:0]     out_pc;
  logic [LANES-1:0]      out_mask;
  logic                  done;

  modport master (
    input  flush, pc_branch, ic_hit, ic_data, fill_valid, fill_tag, out_ready,
    output fetch_pc, miss_req, miss_tag, out_valid, out_instr, out_pc, out_mask, done
  );

  modport slave (
    output flush, pc_branch, ic_hit, ic_data, fill_valid, fill_tag, out_ready,
    input  fetch_pc, miss_req, miss_tag, out_valid, out_instr, out_pc, out_mask, done
  );
endinterface

// File: rtl/fetch_bundle_queue.sv
// Multi-lane instruction fetch with tag-matched miss handling, stop detection and a
// bundle FIFO decoupling fetch from decode.
module fetch_bundle_queue #(
  parameter int                ADDR_W      = 32,
  parameter int                LANES       = 2,
  parameter int                BLOCK_BYTES = 128,
  parameter int                TAG_W       = 10,
  parameter int                QDEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_bundle_queue_if.master bus,
  output logic [1:0]           fsm_state
);
  localparam int BUNDLE = LANES * 4;
  localparam int BLK    = $clog2(BLOCK_BYTES);
  localparam int QW     = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               miss_req;
  logic [TAG_W-1:0]   miss_tag;
  logic               done;

  logic [ADDR_W-1:0]   q_pc    [QDEPTH];
  logic [LANES*32-1:0] q_instr [QDEPTH];
  logic [LANES-1:0]    q_mask  [QDEPTH];
  logic [QW-1:0]       rd_ptr;
  logic [QW-1:0]       wr_ptr;
  logic [QW:0]         count;
  logic [QW:0]         count_nxt;

  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  lane_off;
  logic [LANES-1:0]   mask;
  logic               stop_found;
  logic               seen;
  logic               deq;
  logic               enq;
  logic               space;

  assign base     = fetch_pc & ~ADDR_W'(BUNDLE - 1);
  assign lane_off = (fetch_pc - base) >> 2;

  // Live lanes start at the fetch offset; the first live stop closes the bundle.
  always_comb begin
    seen = 1'b0;
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((ADDR_W'(i) >= lane_off) && !seen) begin
        mask[i] = 1'b1;
        if (bus.ic_data[32*i+21 +: 11] == 11'b0) seen = 1'b1;
      end
    end
    stop_found = seen;
  end

  assign deq   = (count != '0) && bus.out_ready;
  assign space = (count < (QW+1)'(QDEPTH)) || deq;
  assign enq   = !bus.flush && (state == RUN) && bus.ic_hit && space;

  always_comb begin
    count_nxt = count;
    if (bus.flush) count_nxt = '0;
    else           count_nxt = count + (QW+1)'(enq) - (QW+1)'(deq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MISS;
      fetch_pc <= RESET_PC;
      miss_req <= 1'b1;
      miss_tag <= RESET_PC[BLK +: TAG_W];
      done     <= 1'b0;
    end else if (bus.flush) begin
      state    <= RUN;
      fetch_pc <= bus.pc_branch;
      miss_req <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          done <= 1'b0;
          if (bus.ic_hit) begin
            if (enq) begin
              if (stop_found) state <= HALT;
              else            fetch_pc <= base + ADDR_W'(BUNDLE);
            end
          end else begin
            state    <= MISS;
            miss_req <= 1'b1;
            miss_tag <= fetch_pc[BLK +: TAG_W];
          end
        end
        MISS: begin
          done <= 1'b0;
          if (bus.fill_valid && (bus.fill_tag == miss_tag)) begin
            state    <= RUN;
            miss_req <= 1'b0;
          end
        end
        HALT: done <= (count_nxt == '0);
        default: begin
          state <= RUN;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Flush discards the whole queue, including any head decode is taking this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= base;
      q_instr[wr_ptr] <= bus.ic_data;
      q_mask[wr_ptr]  <= mask;
    end
  end

  assign bus.fetch_pc  = fetch_pc;
  assign bus.miss_req  = miss_req;
  assign bus.miss_tag  = miss_tag;
  assign bus.done      = done;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = q_pc[rd_ptr];
  assign bus.out_instr = q_instr[rd_ptr];
  assign bus.out_mask  = (count != '0) ? q_mask[rd_ptr] : '0;
  assign fsm_state     = state;
endmodule
